// File: rtl/board_pkg.sv
// Shared types for the N x N board store: cell encoding, scan directions,
// scan FSM states and the "no position" marker used for run endpoints.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        P1      = 2'b01,
        P2      = 2'b10,
        INVALID = 2'b11
    } cell_t;

    typedef enum logic [1:0] {H, V, D, A} dir_t;

    typedef enum logic [1:0] {IDLE, NEG, POS, CHK} scan_state_t;

    // Widest cell index for the largest legal board (15 x 15).
    localparam int MAX_AW = 8;

    function automatic logic [MAX_AW-1:0] NO_POS(input int unsigned aw);
        NO_POS = MAX_AW'((1 << aw) - 1);
    endfunction

endpackage

// File: rtl/board_step.sv
// One neighbour step from (row, col) along a scan direction, forward or
// reversed, flagging steps that would leave the board (no row/column wrap).
module board_step
    import board_pkg::*;
#(
    parameter  int N  = 3,
    localparam int RW = $clog2(N)
) (
    input  logic [RW-1:0] row_i,
    input  logic [RW-1:0] col_i,
    input  dir_t          dir_i,
    input  logic          neg_i,
    output logic [RW-1:0] row_o,
    output logic [RW-1:0] col_o,
    output logic          in_bounds_o
);

    logic row_mv, col_fwd, col_bwd;
    logic r_up, r_dn, c_up, c_dn;

    always_comb begin
        row_mv  = (dir_i != H);
        col_fwd = (dir_i == H) || (dir_i == D);
        col_bwd = (dir_i == A);
        r_up    = row_mv && !neg_i;
        r_dn    = row_mv && neg_i;
        c_up    = neg_i ? col_bwd : col_fwd;
        c_dn    = neg_i ? col_fwd : col_bwd;

        in_bounds_o = !((r_up && (row_i == RW'(N - 1))) ||
                        (r_dn && (row_i == '0))         ||
                        (c_up && (col_i == RW'(N - 1))) ||
                        (c_dn && (col_i == '0)));

        row_o = row_i;
        if (r_up)      row_o = row_i + RW'(1);
        else if (r_dn) row_o = row_i - RW'(1);

        col_o = col_i;
        if (c_up)      col_o = col_i + RW'(1);
        else if (c_dn) col_o = col_i - RW'(1);
    end

endmodule

// File: rtl/board_state_memory_n.sv
// N x N game board store with legality-checked writes, two registered read
// ports and an incremental K-in-a-row scan around the most recent move.
module board_state_memory_n
    import board_pkg::*;
#(
    parameter  int N   = 3,
    parameter  int K   = 3,
    localparam int AW  = $clog2(N * N),
    localparam int MCW = $clog2(N * N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [AW-1:0]  wr_addr,
    input  logic [1:0]     wr_data,
    output logic           wr_err,
    input  logic [AW-1:0]  rd_addr_a,
    input  logic [AW-1:0]  rd_addr_b,
    output logic [1:0]     rd_data_a,
    output logic [1:0]     rd_data_b,
    output logic           busy,
    output logic           win,
    output logic [1:0]     winner,
    output logic [AW-1:0]  win_start,
    output logic [AW-1:0]  win_end,
    output logic [MCW-1:0] move_count,
    output logic           draw
);

    localparam int RW    = $clog2(N);
    localparam int CW    = $clog2(K + 1);
    localparam int CELLS = N * N;
    localparam logic [MAX_AW-1:0] NO_POS_W  = NO_POS(AW);
    localparam logic [AW-1:0]     NO_POS_AW = NO_POS_W[AW-1:0];

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(int'(a) / N);
    endfunction

    function automatic logic [RW-1:0] col_of(input logic [AW-1:0] a);
        return RW'(int'(a) % N);
    endfunction

    function automatic logic [AW-1:0] lin(input logic [RW-1:0] r, input logic [RW-1:0] c);
        return AW'(int'(r) * N + int'(c));
    endfunction

    cell_t         cells_q [N][N];
    scan_state_t   state_q;
    dir_t          dir_q;
    cell_t         player_q;
    logic [RW-1:0] org_r_q, org_c_q, cur_r_q, cur_c_q;
    logic [RW-1:0] neg_r_q, neg_c_q, pos_r_q, pos_c_q;
    logic [CW-1:0] neg_cnt_q, pos_cnt_q;
    logic [1:0]    rd_a_q, rd_b_q, winner_q;
    logic          wr_err_q, win_q, draw_q;
    logic [AW-1:0] win_start_q, win_end_q;
    logic [MCW-1:0] move_count_q;

    logic [RW-1:0] wr_r, wr_c, nxt_r, nxt_c;
    logic          nxt_ok, addr_ok, data_ok, legal, attempt, accept;
    logic          matched, side_done;
    cell_t         tgt_cell, nxt_cell;
    logic [CW-1:0] side_cnt_d;
    int            run_len;

    board_step #(.N(N)) u_step (
        .row_i       (cur_r_q),
        .col_i       (cur_c_q),
        .dir_i       (dir_q),
        .neg_i       (state_q == NEG),
        .row_o       (nxt_r),
        .col_o       (nxt_c),
        .in_bounds_o (nxt_ok)
    );

    always_comb begin
        wr_r     = row_of(wr_addr);
        wr_c     = col_of(wr_addr);
        addr_ok  = int'(wr_addr) < CELLS;
        tgt_cell = addr_ok ? cells_q[wr_r][wr_c] : INVALID;
        data_ok  = (wr_data == P1) || (wr_data == P2);
        attempt  = wr_valid && wr_ready && !clear;
        legal    = addr_ok && (tgt_cell == EMPTY) && data_ok && !win_q && !draw_q;
        accept   = attempt && legal;

        nxt_cell   = nxt_ok ? cells_q[nxt_r][nxt_c] : EMPTY;
        matched    = nxt_ok && (nxt_cell == player_q);
        side_cnt_d = ((state_q == NEG) ? neg_cnt_q : pos_cnt_q) + CW'(1);
        // A side stops on a mismatch/edge, or once it holds K-1 matches.
        side_done  = !matched || (int'(side_cnt_d) >= K - 1);
        run_len    = 1 + int'(neg_cnt_q) + int'(pos_cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    cells_q[r][c] <= EMPTY;
            state_q <= IDLE;      dir_q <= H;           player_q <= EMPTY;
            org_r_q <= '0;        org_c_q <= '0;        cur_r_q <= '0;   cur_c_q <= '0;
            neg_r_q <= '0;        neg_c_q <= '0;        pos_r_q <= '0;   pos_c_q <= '0;
            neg_cnt_q <= '0;      pos_cnt_q <= '0;
            rd_a_q <= '0;         rd_b_q <= '0;         wr_err_q <= 1'b0;
            win_q <= 1'b0;        winner_q <= '0;       draw_q <= 1'b0;
            win_start_q <= NO_POS_AW;  win_end_q <= NO_POS_AW;  move_count_q <= '0;
        end else if (clear) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    cells_q[r][c] <= EMPTY;
            state_q <= IDLE;      dir_q <= H;           player_q <= EMPTY;
            neg_cnt_q <= '0;      pos_cnt_q <= '0;
            rd_a_q <= '0;         rd_b_q <= '0;         wr_err_q <= 1'b0;
            win_q <= 1'b0;        winner_q <= '0;       draw_q <= 1'b0;
            win_start_q <= NO_POS_AW;  win_end_q <= NO_POS_AW;  move_count_q <= '0;
        end else begin
            wr_err_q <= attempt && !legal;
            rd_a_q <= (int'(rd_addr_a) < CELLS) ? cells_q[row_of(rd_addr_a)][col_of(rd_addr_a)] : EMPTY;
            rd_b_q <= (int'(rd_addr_b) < CELLS) ? cells_q[row_of(rd_addr_b)][col_of(rd_addr_b)] : EMPTY;

            if (accept) begin
                cells_q[wr_r][wr_c] <= cell_t'(wr_data);
                move_count_q <= move_count_q + MCW'(1);
                player_q <= cell_t'(wr_data);
                state_q <= NEG;   dir_q <= H;
                org_r_q <= wr_r;  org_c_q <= wr_c;  cur_r_q <= wr_r;  cur_c_q <= wr_c;
                neg_r_q <= wr_r;  neg_c_q <= wr_c;  pos_r_q <= wr_r;  pos_c_q <= wr_c;
                neg_cnt_q <= '0;  pos_cnt_q <= '0;
            end

            case (state_q)
                NEG: begin
                    if (matched) begin
                        neg_cnt_q <= side_cnt_d;
                        cur_r_q <= nxt_r;  cur_c_q <= nxt_c;
                        neg_r_q <= nxt_r;  neg_c_q <= nxt_c;
                    end
                    if (side_done) begin
                        state_q <= POS;
                        cur_r_q <= org_r_q;  cur_c_q <= org_c_q;
                    end
                end
                POS: begin
                    if (matched) begin
                        pos_cnt_q <= side_cnt_d;
                        cur_r_q <= nxt_r;  cur_c_q <= nxt_c;
                        pos_r_q <= nxt_r;  pos_c_q <= nxt_c;
                    end
                    if (side_done) state_q <= CHK;
                end
                CHK: begin
                    if (run_len >= K) begin
                        win_q       <= 1'b1;
                        winner_q    <= player_q;
                        win_start_q <= lin(neg_r_q, neg_c_q);
                        win_end_q   <= lin(pos_r_q, pos_c_q);
                        state_q     <= IDLE;
                    end else if (dir_q == A) begin
                        state_q <= IDLE;
                        if (int'(move_count_q) == CELLS) draw_q <= 1'b1;
                    end else begin
                        dir_q   <= dir_t'(dir_q + 2'd1);
                        state_q <= NEG;
                        cur_r_q <= org_r_q;  cur_c_q <= org_c_q;
                        neg_r_q <= org_r_q;  neg_c_q <= org_c_q;
                        pos_r_q <= org_r_q;  pos_c_q <= org_c_q;
                        neg_cnt_q <= '0;     pos_cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign wr_ready   = !busy;
    assign wr_err     = wr_err_q;
    assign rd_data_a  = rd_a_q;
    assign rd_data_b  = rd_b_q;
    assign win        = win_q;
    assign winner     = winner_q;
    assign win_start  = win_start_q;
    assign win_end    = win_end_q;
    assign move_count = move_count_q;
    assign draw       = draw_q;

endmodule

// File: tb/tb_board_state_memory_n.sv
// Directed bench: a 3x3/K=3 board and a 5x5/K=4 board share stimulus;
// `sel` routes writes and observation to one of them at a time.
module tb_board_state_memory_n;

    logic       clk = 1'b0;
    logic       reset, clear, wr_valid, sel;
    logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [1:0] wr_data;

    logic       wr_ready3, wr_err3, busy3, win3, draw3;
    logic [1:0] rd_a3, rd_b3, winner3;
    logic [3:0] ws3, we3, mc3;
    logic       wr_ready5, wr_err5, busy5, win5, draw5;
    logic [1:0] rd_a5, rd_b5, winner5;
    logic [4:0] ws5, we5, mc5;

    logic       wr_ready_m, wr_err_m, busy_m, win_m, draw_m;
    logic [1:0] rd_a_m, winner_m;
    logic [4:0] ws_m, we_m, mc_m;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic err;

    always #5 clk = ~clk;

    board_state_memory_n #(.N(3), .K(3)) u_dut3 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_valid(wr_valid & ~sel), .wr_ready(wr_ready3),
        .wr_addr(wr_addr[3:0]), .wr_data(wr_data), .wr_err(wr_err3),
        .rd_addr_a(rd_addr_a[3:0]), .rd_addr_b(rd_addr_b[3:0]),
        .rd_data_a(rd_a3), .rd_data_b(rd_b3),
        .busy(busy3), .win(win3), .winner(winner3),
        .win_start(ws3), .win_end(we3), .move_count(mc3), .draw(draw3)
    );

    board_state_memory_n #(.N(5), .K(4)) u_dut5 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_valid(wr_valid & sel), .wr_ready(wr_ready5),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err5),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_a5), .rd_data_b(rd_b5),
        .busy(busy5), .win(win5), .winner(winner5),
        .win_start(ws5), .win_end(we5), .move_count(mc5), .draw(draw5)
    );

    assign wr_ready_m = sel ? wr_ready5 : wr_ready3;
    assign wr_err_m   = sel ? wr_err5   : wr_err3;
    assign busy_m     = sel ? busy5     : busy3;
    assign win_m      = sel ? win5      : win3;
    assign draw_m     = sel ? draw5     : draw3;
    assign rd_a_m     = sel ? rd_a5     : rd_a3;
    assign winner_m   = sel ? winner5   : winner3;
    assign ws_m       = sel ? ws5       : {1'b0, ws3};
    assign we_m       = sel ? we5       : {1'b0, we3};
    assign mc_m       = sel ? mc5       : {1'b0, mc3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Present one move for a cycle; optionally wait out the scan, counting
    // the cycles wr_ready stays low.
    task automatic mv(input int addr, input int data, input bit wait_idle,
                      output int n, output logic e);
        @(negedge clk);
        wr_addr  = 5'(addr);
        wr_data  = 2'(data);
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        e = wr_err_m;
        n = 0;
        if (wait_idle) begin
            while (!wr_ready_m && n < 400) begin
                n++;
                @(negedge clk);
            end
            if (n >= 400) chk("busy_bound", 32'(n), 32'd0);
        end
        $display("move sel=%0d addr=%0d data=%0d err=%0d busy_cycles=%0d", sel, addr, data, e, n);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic chk_idle_state(input string tag, input logic [4:0] nopos);
        chk({tag, "_busy"},   32'(busy_m),   32'd0);
        chk({tag, "_win"},    32'(win_m),    32'd0);
        chk({tag, "_winner"}, 32'(winner_m), 32'd0);
        chk({tag, "_start"},  32'(ws_m),     32'(nopos));
        chk({tag, "_end"},    32'(we_m),     32'(nopos));
        chk({tag, "_mc"},     32'(mc_m),     32'd0);
        chk({tag, "_draw"},   32'(draw_m),   32'd0);
        chk({tag, "_err"},    32'(wr_err_m), 32'd0);
        chk({tag, "_rd"},     32'(rd_a_m),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; sel = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr_a = 5'd4; rd_addr_b = 5'd13;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_state("reset3", 5'd15);
        chk("reset3_ready", 32'(wr_ready_m), 32'd1);

        // Centre move: 4 directions x (1 NEG + 1 POS + 1 CHK).
        mv(4, 1, 1'b1, cyc, err);
        chk("centre_busy", 32'(cyc), 32'd12);
        chk("centre_err",  32'(err), 32'd0);
        chk("centre_win",  32'(win_m), 32'd0);
        chk("centre_mc",   32'(mc_m), 32'd1);

        mv(4, 2, 1'b1, cyc, err);
        chk("occupied_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("occupied_pulse", 32'(wr_err_m), 32'd0);
        chk("occupied_mc", 32'(mc_m), 32'd1);
        chk("occupied_rd", 32'(rd_a_m), 32'd1);
        mv(9, 2, 1'b1, cyc, err);
        chk("addr9_err", 32'(err), 32'd1);
        chk("addr9_mc",  32'(mc_m), 32'd1);
        mv(0, 3, 1'b1, cyc, err);
        chk("data11_err", 32'(err), 32'd1);
        chk("data11_mc",  32'(mc_m), 32'd1);
        mv(0, 0, 1'b1, cyc, err);
        chk("data00_err", 32'(err), 32'd1);
        chk("oor_read", 32'(sel ? rd_b5 : rd_b3), 32'd0);

        // Row win along H on the first direction: NEG 2, POS 1, CHK 1.
        do_clear();
        mv(0, 1, 1'b1, cyc, err);
        mv(3, 2, 1'b1, cyc, err);
        mv(1, 1, 1'b1, cyc, err);
        mv(4, 2, 1'b1, cyc, err);
        mv(2, 1, 1'b1, cyc, err);
        chk("row_busy",   32'(cyc), 32'd4);
        chk("row_win",    32'(win_m), 32'd1);
        chk("row_winner", 32'(winner_m), 32'd1);
        chk("row_start",  32'(ws_m), 32'd0);
        chk("row_end",    32'(we_m), 32'd2);
        chk("row_mc",     32'(mc_m), 32'd5);
        mv(5, 2, 1'b1, cyc, err);
        chk("after_win_err", 32'(err), 32'd1);
        chk("after_win_mc",  32'(mc_m), 32'd5);

        // Anti-diagonal: H, V, D miss (3 cycles each), A = 2 + 2 + 1.
        do_clear();
        mv(2, 2, 1'b1, cyc, err);
        mv(6, 2, 1'b1, cyc, err);
        mv(4, 2, 1'b1, cyc, err);
        chk("anti_busy",   32'(cyc), 32'd14);
        chk("anti_winner", 32'(winner_m), 32'd2);
        chk("anti_start",  32'(ws_m), 32'd2);
        chk("anti_end",    32'(we_m), 32'd6);

        // Draw: X O X / X O O / O X X, X = P1.
        do_clear();
        mv(0, 1, 1'b1, cyc, err);
        mv(1, 2, 1'b1, cyc, err);
        mv(2, 1, 1'b1, cyc, err);
        mv(4, 2, 1'b1, cyc, err);
        mv(3, 1, 1'b1, cyc, err);
        mv(5, 2, 1'b1, cyc, err);
        mv(7, 1, 1'b1, cyc, err);
        mv(6, 2, 1'b1, cyc, err);
        chk("draw_early", 32'(draw_m), 32'd0);
        mv(8, 1, 1'b1, cyc, err);
        chk("draw_busy",  32'(cyc), 32'd13);
        chk("draw_flag",  32'(draw_m), 32'd1);
        chk("draw_win",   32'(win_m), 32'd0);
        chk("draw_mc",    32'(mc_m), 32'd9);
        chk("draw_start", 32'(ws_m), 32'd15);
        mv(0, 2, 1'b1, cyc, err);
        chk("draw_10th_err", 32'(err), 32'd1);

        // 5x5, K=4: P1 row 6..9 completed at 8.
        sel = 1'b1;
        do_clear();
        @(negedge clk);
        chk_idle_state("reset5", 5'd31);
        mv(9, 1, 1'b1, cyc, err);
        mv(20, 2, 1'b1, cyc, err);
        mv(6, 1, 1'b1, cyc, err);
        mv(21, 2, 1'b1, cyc, err);
        mv(7, 1, 1'b1, cyc, err);
        mv(22, 2, 1'b1, cyc, err);
        chk("n5_nowin", 32'(win_m), 32'd0);
        mv(8, 1, 1'b1, cyc, err);
        chk("n5_busy",   32'(cyc), 32'd6);
        chk("n5_win",    32'(win_m), 32'd1);
        chk("n5_winner", 32'(winner_m), 32'd1);
        chk("n5_start",  32'(ws_m), 32'd6);
        chk("n5_end",    32'(we_m), 32'd9);
        chk("n5_mc",     32'(mc_m), 32'd7);

        // clear two cycles into a scan.
        do_clear();
        rd_addr_a = 5'd12;
        mv(12, 1, 1'b0, cyc, err);
        @(negedge clk);
        chk("clr_pre_busy", 32'(busy_m), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_idle_state("clr_mid", 5'd31);
        @(negedge clk);
        chk("clr_cell", 32'(rd_a_m), 32'd0);

        // Asynchronous reset during a scan.
        rd_addr_a = 5'd0;
        mv(0, 2, 1'b0, cyc, err);
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy_m), 32'd1);
        chk("rst_pre_rd",   32'(rd_a_m), 32'd2);
        reset = 1'b1;
        #2;
        chk_idle_state("rst_mid", 5'd31);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cell", 32'(rd_a_m), 32'd0);
        chk("rst_ready", 32'(wr_ready_m), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_state_memory_n.md
# board_state_memory_n

Parametrised N×N game-board register file with K-in-a-row win detection. It replaces the fixed 3×3 board store between the game controller and the VGA renderer. It adds:
- a write handshake with legality checks,
- an incremental multi-cycle line scan around the last move,
- a move counter with draw detection,
- strike-line endpoints for any board size.

## Interface
- `N`, 3 — board side; legal range 3..15.
- `K`, 3 — win run length; legal range 3..N.
- `AW`, `$clog2(N*N)` — derived cell-index width; not overridable.
- `clk` in 1 — single clock.
- `reset` in 1 — asynchronous, active-high; returns all state to reset values.
- `clear` in 1 — synchronous game restart: all cells EMPTY, flags and counter to reset values, aborts any scan.
- `wr_valid` in 1 — move request.
- `wr_ready` out 1 — equals `!busy`.
- `wr_addr` in AW — linear index r*N+c.
- `wr_data` in 2 — `P1`=01 or `P2`=10.
- `wr_err` out 1 — one-cycle pulse, move rejected.
- `rd_addr_a`, `rd_addr_b` in AW — read ports.
- `rd_data_a`, `rd_data_b` out 2 — registered cell contents.
- `busy` out 1 — scan in progress.
- `win` out 1 — winning run found.
- `winner` out 2 — 01/10 when `win`, else 00.
- `win_start`, `win_end` out AW — run endpoints; all-ones when `!win`.
- `move_count` out `$clog2(N*N+1)` — accepted moves.
- `draw` out 1 — board full and `!win`.

## Operation
- **Cell encoding:** `EMPTY`=00, `P1`=01, `P2`=10, `INVALID`=11.
- **Acceptance:** a move is accepted on a cycle with `wr_valid && wr_ready && !clear` when all of the following hold:
  - `wr_addr` < N*N;
  - the target cell is `EMPTY`;
  - `wr_data` ∈ {01,10};
  - `!win`;
  - `!draw`.
- **Accepted move:** the cell is written, `move_count` increments, and the scan starts.
- **Rejected move:** otherwise, `wr_err` pulses the next cycle; no state changes.
- **Reads:** 1-cycle registered latency, read-before-write on same-cycle address collision. An out-of-range address reads 00.
- **Scan FSM:** `IDLE` → `NEG` → `POS` → `CHK` → (next direction `NEG` | `IDLE`).
  - Directions are scanned in order H(0,+1), V(+1,0), D(+1,+1), A(+1,−1).
  - `NEG` steps opposite the direction vector from the written cell, one neighbour per cycle.
  - A side ends on the cycle whose cell is out-of-bounds or ≠ player, or on the cycle reaching K−1 matches. The terminating cycle is counted.
  - `POS` does the same along the vector.
  - `CHK`: run = 1 + neg matches + pos matches.
    - If run ≥ K: latch `win`, `winner`, `win_start` (farthest NEG match, else the written cell) and `win_end` (farthest POS match, else the written cell), then go to `IDLE`.
    - Otherwise advance to the next direction. After A, go to `IDLE`.
- **Full board:** on the `CHK` that ends the scan with `move_count`==N*N and no win, set `draw`.
- **Bounds:** column wrap is illegal. A step from c=N−1 with +c, or from c=0 with −c, is out-of-bounds.
- **Priority:** `reset` > `clear` > write.
  - `clear` during a scan aborts it; `busy` is 0 the next cycle.
  - `clear` with `wr_valid` drops the write with no `wr_err`.

## Timing
- **Reset values:**
  - all cells `EMPTY`;
  - `rd_data_*`=0, `busy`=0, `wr_err`=0, `win`=0, `winner`=00, `draw`=0, `move_count`=0;
  - `win_start`/`win_end`=all-ones;
  - FSM in `IDLE`.
- **Accepting edge E0:** the cell is updated, `busy`=1 and the FSM is in `NEG`(H).
- **Busy length:** `busy` stays high for the sum over scanned directions of (NEG cycles + POS cycles + 1). `busy` falls on the edge that exits `CHK` into `IDLE`.
- **Flag timing:** `win`/`winner`/endpoints/`draw` change on that same edge.
- **Next move:** `wr_ready` is high the cycle after `busy` falls.
- **Worst-case scan length:** 4·(2(K−1)+1) cycles.
- **Read ports:** operate during a scan.

## Structure
- **`board_pkg`:**
  - `cell_t` enum (`EMPTY`, `P1`, `P2`, `INVALID`);
  - `dir_t` enum (`H`, `V`, `D`, `A`);
  - `scan_state_t` enum (`IDLE`, `NEG`, `POS`, `CHK`);
  - `NO_POS` function returning all-ones of AW.
- **`board_step` sub-module (combinational):**
  - inputs: row, col, `dir_t`, sign;
  - outputs: next row/col, `in_bounds`.
- Cells are held as row/col internally and converted to linear at the ports.

## Test plan
- **Centre timing:** N=3,K=3, empty board, write `P1`@4 → `wr_ready` low for exactly 12 cycles, `win`=0, `move_count`=1.
- **Row win:** `P1`@0, `P2`@3, `P1`@1, `P2`@4, `P1`@2 → after the last scan `win`=1, `winner`=01, `win_start`=0, `win_end`=2. A further write gives a `wr_err` pulse.
- **Anti-diagonal endpoints:** `P2`@2, `P2`@6, then `P2`@4 → `win_start`=2, `win_end`=6 (direction A).
- **Illegal moves:** each of the following pulses `wr_err` for 1 cycle with `move_count` unchanged:
  - `P2`@4 onto occupied `P1`@4 (`rd_data_a`@4 = 01 after);
  - `wr_addr`=9;
  - `wr_data`=11.
- **Draw:** fill X O X / X O O / O X X (X=`P1`) → after move 9, `draw`=1, `win`=0, `move_count`=9, `win_start`=15. A 10th write gives `wr_err`.
- **Generalised size and restart:** N=5,K=4, `P1`@9, 6, 7, 8 (interleaved `P2` elsewhere) → `win` with start=6, end=9. Then:
  - `clear` asserted 2 cycles into a later scan → next cycle `busy`=0 and all outputs at reset values;
  - async `reset` mid-scan → same result.
